// File: rtl/sa_os_tile_mac_if.sv
// sa_os_tile_mac_if
//   Bundles the beat-input and tile-output handshakes of sa_os_tile_mac.
//
//   Handshake semantics (both channels): a transfer happens on a rising clk
//   edge where valid and ready are both high. A source holding valid must keep
//   its payload stable until that edge. Valid seen while ready is low is
//   ignored, and so is any payload sideband (last, accumulate) that goes with it.
//
//   Signals (named from the tile's point of view):
//     beat_vld   in   input beat valid
//     beat_rdy   out  tile can accept a beat
//     last       in   beat is the final K beat of the tile
//     accumulate in   sampled on a tile's first beat: 0 clear, 1 add onto held result
//     x          in   X column, element i at [i*D_W +: D_W]
//     w          in   W row, element j at [j*D_W +: D_W]
//     tile_vld   out  result tile valid
//     tile_rdy   in   consumer accepts tile
//     tile       out  element (i,j) at [(i*SA_C+j)*ACC_W +: ACC_W]
//     busy       out  FSM not idle
//     dbg_state  out  raw FSM state (0 IDLE, 1 FEED, 2 DRAIN, 3 OUT)
//   Modports: master = beat source / tile consumer, slave = the tile.
interface sa_os_tile_mac_if #(
    parameter int D_W   = 8,
    parameter int SA_R  = 16,
    parameter int SA_C  = 16,
    parameter int ACC_W = 32
);
    logic                        beat_vld;
    logic                        beat_rdy;
    logic                        last;
    logic                        accumulate;
    logic [SA_R*D_W-1:0]         x;
    logic [SA_C*D_W-1:0]         w;
    logic                        tile_vld;
    logic                        tile_rdy;
    logic [SA_R*SA_C*ACC_W-1:0]  tile;
    logic                        busy;
    logic [1:0]                  dbg_state;

    modport master (
        output beat_vld, last, accumulate, x, w, tile_rdy,
        input  beat_rdy, tile_vld, tile, busy, dbg_state
    );

    modport slave (
        input  beat_vld, last, accumulate, x, w, tile_rdy,
        output beat_rdy, tile_vld, tile, busy, dbg_state
    );
endinterface

// File: rtl/sa_os_tile_mac.sv
// sa_os_tile_mac
//   Output-stationary systolic matrix-multiply tile. K beats of an X column
//   (SA_R elements) and a W row (SA_C elements) are accepted, skewed so that
//   PE(i,j) sees beat k one edge after i+j stages, and accumulated as signed
//   products in an SA_R x SA_C grid. The finished tile is shown on a
//   valid/ready output straight from the accumulators.
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  sa_os_tile_mac_if.slave (beat input, tile output, busy, dbg_state)
//
//   Optional feature: define SA_OS_SAT_EN to saturate every PE add to the
//   signed ACC_W range; otherwise accumulators wrap in two's complement.
module sa_os_tile_mac #(
    parameter int D_W   = 8,
    parameter int SA_R  = 16,
    parameter int SA_C  = 16,
    parameter int ACC_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    sa_os_tile_mac_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Tag carried alongside X through the skew and across each PE row.
    typedef struct packed {
        logic vld;
        logic first;
        logic mode;
    } tag_t;

    localparam int CNT_W = $clog2(SA_R + SA_C + 1);
    localparam int PW    = 2 * D_W;
    localparam int SW    = ACC_W + 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] drain_cnt;
    logic             rdy_en;
    logic             rdy_w;
    logic             accept;

    // rdy_en holds ready low until the first edge after reset release.
    assign rdy_w  = rdy_en && (state == IDLE || state == FEED);
    assign accept = bus.beat_vld && rdy_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            rdy_en    <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            // Counts edges spent in DRAIN; zero on the cycle DRAIN is entered.
            if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                drain_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.beat_rdy  = rdy_w;
        bus.tile_vld  = (state == OUT);
        bus.busy      = (state != IDLE);
        bus.dbg_state = state;
        case (state)
            IDLE:  if (accept) state_nxt = bus.last ? DRAIN : FEED;
            FEED:  if (accept && bus.last) state_nxt = DRAIN;
            DRAIN: if (drain_cnt == CNT_W'(SA_R + SA_C - 1)) state_nxt = OUT;
            OUT:   if (bus.tile_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Skew delay lines. Index 0 is the stage-0 capture; row i taps xs[i] and
    // column j taps ws[j], giving the i / j extra stages of delay.
    logic [SA_R*D_W-1:0] xs [SA_R];
    logic [SA_C*D_W-1:0] ws [SA_C];
    tag_t                ts [SA_R];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < SA_R; d++) begin
                xs[d] <= '0;
                ts[d] <= '0;
            end
            for (int d = 0; d < SA_C; d++) ws[d] <= '0;
        end else begin
            ts[0].vld   <= accept;
            ts[0].first <= (state == IDLE);
            ts[0].mode  <= bus.accumulate;
            if (accept) begin
                xs[0] <= bus.x;
                ws[0] <= bus.w;
            end
            for (int d = 1; d < SA_R; d++) begin
                xs[d] <= xs[d-1];
                ts[d] <= ts[d-1];
            end
            for (int d = 1; d < SA_C; d++) ws[d] <= ws[d-1];
        end
    end

    // PE grid: X and its tag move right one PE per edge, W moves down.
    for (genvar i = 0; i < SA_R; i++) begin : g_row
        for (genvar j = 0; j < SA_C; j++) begin : g_col
            logic signed [D_W-1:0]   x_in, w_in, x_r, w_r;
            tag_t                    t_in, t_r;
            logic signed [PW-1:0]    prod;
            logic signed [ACC_W-1:0] prod_ext, base, acc_nxt, acc_r;

            if (j == 0) begin : g_xl
                assign x_in = xs[i][i*D_W +: D_W];
                assign t_in = ts[i];
            end else begin : g_xr
                assign x_in = g_row[i].g_col[j-1].x_r;
                assign t_in = g_row[i].g_col[j-1].t_r;
            end

            if (i == 0) begin : g_wt
                assign w_in = ws[j][j*D_W +: D_W];
            end else begin : g_wb
                assign w_in = g_row[i-1].g_col[j].w_r;
            end

            assign prod     = PW'(x_in) * PW'(w_in);
            assign prod_ext = ACC_W'(prod);
            // A tile's first beat restarts from zero unless accumulate was set.
            assign base     = (t_in.first && !t_in.mode) ? '0 : acc_r;

`ifdef SA_OS_SAT_EN
            logic signed [SW-1:0] sum_w;
            assign sum_w = SW'(base) + SW'(prod_ext);
            always_comb begin
                acc_nxt = sum_w[ACC_W-1:0];
                if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
                    acc_nxt = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
                end
            end
`else
            assign acc_nxt = base + prod_ext;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x_r   <= '0;
                    w_r   <= '0;
                    t_r   <= '0;
                    acc_r <= '0;
                end else begin
                    x_r <= x_in;
                    w_r <= w_in;
                    t_r <= t_in;
                    if (t_in.vld) acc_r <= acc_nxt;
                end
            end

            assign bus.tile[(i*SA_C+j)*ACC_W +: ACC_W] = acc_r;
        end
    end
endmodule

// File: tb/tb_sa_os_tile_mac.sv
// tb_sa_os_tile_mac
//   Directed bench for a 4x4, D_W=8, ACC_W=16 sa_os_tile_mac. Expected tile
//   values are hand-computed constants pushed into exp_q and popped per element.
module tb_sa_os_tile_mac;
  localparam int D_W   = 8;
  localparam int SA_R  = 4;
  localparam int SA_C  = 4;
  localparam int ACC_W = 16;
  localparam int NE    = SA_R * SA_C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sa_os_tile_mac_if #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .ACC_W(ACC_W)) bus ();

  sa_os_tile_mac #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  logic [ACC_W-1:0] exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checks ----------------
  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SA_R*D_W-1:0] xfill(input logic [D_W-1:0] v);
    logic [SA_R*D_W-1:0] r;
    for (int i = 0; i < SA_R; i++) r[i*D_W +: D_W] = v;
    return r;
  endfunction

  function automatic logic [SA_C*D_W-1:0] wfill(input logic [D_W-1:0] v);
    logic [SA_C*D_W-1:0] r;
    for (int j = 0; j < SA_C; j++) r[j*D_W +: D_W] = v;
    return r;
  endfunction

  // Presents a beat and returns #1 after the edge that accepted it.
  task automatic send(input logic [SA_R*D_W-1:0] xv, input logic [SA_C*D_W-1:0] wv,
                      input logic lst, input logic acc);
    int n = 0;
    bus.x          = xv;
    bus.w          = wv;
    bus.last       = lst;
    bus.accumulate = acc;
    bus.beat_vld   = 1'b1;
    while (!bus.beat_rdy && n < 50) begin
      tick();
      n++;
    end
    chk_bit("send_rdy", bus.beat_rdy, 1'b1);
    tick();
    bus.beat_vld   = 1'b0;
    bus.last       = 1'b0;
    bus.accumulate = 1'b0;
  endtask

  task automatic wait_tile(input string tag);
    int n = 0;
    while (!bus.tile_vld && n < 100) begin
      tick();
      n++;
    end
    chk_bit({tag, "_vld"}, bus.tile_vld, 1'b1);
  endtask

  task automatic push_all(input logic [ACC_W-1:0] v);
    for (int e = 0; e < NE; e++) exp_q.push_back(v);
  endtask

  // Scoreboard: pops one expected value per element, in (i*SA_C+j) order.
  task automatic check_tile(input string tag);
    logic [ACC_W-1:0] e_v;
    for (int e = 0; e < NE; e++) begin
      e_v = exp_q.pop_front();
      chk_val($sformatf("%s_e%0d", tag, e), bus.tile[e*ACC_W +: ACC_W], e_v);
    end
  endtask

  task automatic take_tile(input string tag);
    bus.tile_rdy = 1'b1;
    tick();
    bus.tile_rdy = 1'b0;
    chk_bit({tag, "_vld_low"}, bus.tile_vld, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [SA_R*D_W-1:0] xv;
    logic [SA_C*D_W-1:0] wv;
    logic pat [7];
    logic vld_seen;
    int   beat;
    int   n;

    bus.beat_vld   = 1'b0;
    bus.last       = 1'b0;
    bus.accumulate = 1'b0;
    bus.x          = '0;
    bus.w          = '0;
    bus.tile_rdy   = 1'b0;

    // Reset state
    repeat (2) tick();
    chk_bit("rst_rdy", bus.beat_rdy, 1'b0);
    chk_bit("rst_out_vld", bus.tile_vld, 1'b0);
    chk_bit("rst_busy", bus.busy, 1'b0);
    chk_bit("rst_tile_zero", |bus.tile, 1'b0);
    rst = 1'b0;
    chk_bit("rel_rdy_before_edge", bus.beat_rdy, 1'b0);
    tick();
    chk_bit("rel_rdy_after_edge", bus.beat_rdy, 1'b1);

    // K=1, x=1, w=2. Beat accepted at edge t; the last PE updates at t+7 and
    // tile_vld appears after edge t+8 (the ninth edge counting t itself).
    send(xfill(8'd1), wfill(8'd2), 1'b1, 1'b0);
    chk_bit("k1_state_drain", bus.dbg_state == 2'd2, 1'b1);
    chk_bit("k1_rdy_drain", bus.beat_rdy, 1'b0);
    repeat (7) tick();
    chk_bit("k1_vld_at_t7", bus.tile_vld, 1'b0);
    chk_bit("k1_busy_at_t7", bus.busy, 1'b1);
    tick();
    chk_bit("k1_vld_at_t8", bus.tile_vld, 1'b1);
    push_all(16'd2);
    check_tile("k1");
    take_tile("k1");
    chk_bit("k1_rdy_after_hs", bus.beat_rdy, 1'b1);

    // K=4 unit-vector X, W row k = {4k..4k+3} -> tile(i,j) = 4i+j
    for (int k = 0; k < 4; k++) begin
      xv = '0;
      xv[k*D_W +: D_W] = 8'd1;
      for (int j = 0; j < SA_C; j++) wv[j*D_W +: D_W] = D_W'(4*k + j);
      send(xv, wv, k == 3, 1'b0);
    end
    wait_tile("unit");
    for (int e = 0; e < NE; e++) exp_q.push_back(ACC_W'(e));
    check_tile("unit");
    take_tile("unit");

    // Tile A: clear, 4 x (3*4) = 48
    for (int k = 0; k < 4; k++) send(xfill(8'd3), wfill(8'd4), k == 3, 1'b0);
    wait_tile("tA");
    push_all(16'd48);
    check_tile("tA");
    take_tile("tA");
    // Tile B: accumulate only on the first beat -> 96
    for (int k = 0; k < 4; k++) send(xfill(8'd3), wfill(8'd4), k == 3, k == 0);
    wait_tile("tB");
    push_all(16'd96);
    check_tile("tB");
    take_tile("tB");
    // Tile C: clear on first beat; accumulate=1 on later beats is ignored -> 48
    for (int k = 0; k < 4; k++) send(xfill(8'd3), wfill(8'd4), k == 3, k != 0);
    wait_tile("tC");
    push_all(16'd48);
    check_tile("tC");
    take_tile("tC");

    // Bubbles: valid pattern 1,0,0,1,1,0,1 with garbage data on idle slots
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    beat = 0;
    for (int s = 0; s < 7; s++) begin
      if (pat[s]) begin
        send(xfill(8'd3), wfill(8'd4), beat == 3, 1'b0);
        beat++;
      end else begin
        bus.x = xfill(8'd99);
        bus.w = wfill(8'd99);
        tick();
      end
    end
    // Offer a beat during DRAIN/OUT; it must be refused and ignored.
    bus.x          = xfill(8'd5);
    bus.w          = wfill(8'd5);
    bus.last       = 1'b1;
    bus.accumulate = 1'b1;
    bus.beat_vld   = 1'b1;
    n = 0;
    while (!bus.tile_vld && n < 50) begin
      chk_bit($sformatf("bub_rdy_drain_%0d", n), bus.beat_rdy, 1'b0);
      tick();
      n++;
    end
    chk_bit("bub_vld", bus.tile_vld, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk_bit($sformatf("bub_stall_vld_%0d", c), bus.tile_vld, 1'b1);
      chk_bit($sformatf("bub_stall_rdy_%0d", c), bus.beat_rdy, 1'b0);
      chk_val($sformatf("bub_stall_e0_%0d", c), bus.tile[0 +: ACC_W], 16'd48);
      chk_val($sformatf("bub_stall_e15_%0d", c), bus.tile[15*ACC_W +: ACC_W], 16'd48);
      tick();
    end
    bus.beat_vld   = 1'b0;
    bus.last       = 1'b0;
    bus.accumulate = 1'b0;
    push_all(16'd48);
    check_tile("bub");
    take_tile("bub");

    // Overflow: 3 x 127*127 = 48387 (wrap -> 0xBD03 = -17149, sat -> 0x7FFF)
    for (int k = 0; k < 3; k++) send(xfill(8'd127), wfill(8'd127), k == 2, 1'b0);
    wait_tile("ovf_pos");
`ifdef SA_OS_SAT_EN
    push_all(16'h7FFF);
`else
    push_all(16'hBD03);
`endif
    check_tile("ovf_pos");
    take_tile("ovf_pos");

    // Negative: 3 x (-128*127) = -48768 (wrap -> 0x4180 = 16768, sat -> 0x8000)
    for (int k = 0; k < 3; k++) send(xfill(8'h80), wfill(8'd127), k == 2, 1'b0);
    wait_tile("ovf_neg");
`ifdef SA_OS_SAT_EN
    push_all(16'h8000);
`else
    push_all(16'h4180);
`endif
    check_tile("ovf_neg");
    take_tile("ovf_neg");

    // Reset during FEED after 2 beats: tile discarded, held results lost
    send(xfill(8'd1), wfill(8'd1), 1'b0, 1'b0);
    send(xfill(8'd1), wfill(8'd1), 1'b0, 1'b0);
    chk_bit("mid_busy_feed", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_bit("mid_rst_busy", bus.busy, 1'b0);
    chk_bit("mid_rst_rdy", bus.beat_rdy, 1'b0);
    chk_bit("mid_rst_tile_zero", |bus.tile, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk_bit("mid_rdy_after_rel", bus.beat_rdy, 1'b1);
    vld_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      vld_seen = vld_seen | bus.tile_vld;
      tick();
    end
    chk_bit("mid_no_out_vld", vld_seen, 1'b0);
    chk_bit("mid_tile_still_zero", |bus.tile, 1'b0);

    // Accumulate onto the cleared result: K=1, x=1, w=1 -> 1
    send(xfill(8'd1), wfill(8'd1), 1'b1, 1'b1);
    wait_tile("post_rst");
    push_all(16'd1);
    check_tile("post_rst");
    take_tile("post_rst");

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
